bsg_manycore_link_to_axil_rx_rd: RTL and testbench

//  AXI4-Lite read-channel (AR/R) slave for the host RX request path; sits directly downstream of the RX stage.

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 22 ++
 rtl/bsg_dff_reset_en.sv | 24 ++
 rtl/bsg_manycore_link_to_axil_rx_rd.sv | 125 ++++++++++++
 tb/tb_bsg_manycore_link_to_axil_rx_rd.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared definitions for the manycore-link to AXI4-Lite host bridge:
// register offsets, AXI-Lite response codes and read-channel FSM states.
package bsg_manycore_link_to_axil_pkg;

    // Byte offsets within the bridge's AXI-Lite window; bits [1:0] are ignored on decode.
    localparam logic [7:0] rx_data_offset_gp  = 8'h00;
    localparam logic [7:0] rx_occ_offset_gp   = 8'h04;
    localparam logic [7:0] rx_uflow_offset_gp = 8'h08;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Register with synchronous active-high reset to a parameterised value and a load enable.
module bsg_dff_reset_en #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            data_q <= reset_val_p;
        else if (en_i)
            data_q <= data_i;
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_manycore_link_to_axil_rx_rd.sv
// AXI4-Lite read slave for the host RX path: pops RX words, reports RX occupancy.
// Optional BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN adds a saturating RX underflow counter at 0x08.
module bsg_manycore_link_to_axil_rx_rd
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int axil_data_width_p   = 32,
    parameter int axil_addr_width_p   = 32,
    parameter int req_credits_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    input  logic [axil_data_width_p-1:0]   rx_data_i,
    input  logic                           rx_v_i,
    output logic                           rx_ready_o,
    input  logic [req_credits_width_p-1:0] rx_credits_i
);

    rd_state_e state_q, state_d;

    logic                         ar_hs;
    logic [5:0]                   word_off;
    logic                         is_data, is_occ;
    logic [axil_data_width_p-1:0] credits_ext;
    logic [axil_data_width_p-1:0] rdata_d;
    axil_resp_e                   rresp_d;
    logic [axil_data_width_p+1:0] resp_q;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_araddr_i[axil_addr_width_p-1:8], s_axil_araddr_i[1:0]};

    // Holding arready low during reset makes an AR coincident with reset a no-op.
    assign s_axil_arready_o = (state_q == IDLE) & ~reset_i;
    assign s_axil_rvalid_o  = (state_q == RESP);
    assign ar_hs            = s_axil_arvalid_i & s_axil_arready_o;

    assign word_off = s_axil_araddr_i[7:2];
    assign is_data  = (word_off == rx_data_offset_gp[7:2]);
    assign is_occ   = (word_off == rx_occ_offset_gp[7:2]);

    assign rx_ready_o = ar_hs & is_data & rx_v_i;

    always_comb begin
        credits_ext                          = '0;
        credits_ext[req_credits_width_p-1:0] = rx_credits_i;
    end

`ifdef BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN
    logic [axil_data_width_p-1:0] uflow_q, uflow_d;
    logic                         is_uflow, uflow_inc;

    assign is_uflow  = (word_off == rx_uflow_offset_gp[7:2]);
    assign uflow_inc = ar_hs & is_data & ~rx_v_i;

    always_comb begin
        uflow_d = uflow_q;
        if (uflow_inc && (uflow_q != '1))
            uflow_d = uflow_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            uflow_q <= '0;
        else
            uflow_q <= uflow_d;
    end
`endif

    always_comb begin
        rdata_d = '0;
        rresp_d = DECERR;
        if (is_data) begin
            rresp_d = rx_v_i ? OKAY : SLVERR;
            if (rx_v_i)
                rdata_d = rx_data_i;
        end else if (is_occ) begin
            rdata_d = credits_ext;
            rresp_d = OKAY;
        end
`ifdef BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN
        else if (is_uflow) begin
            rdata_d = uflow_q;
            rresp_d = OKAY;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = RESP;
            RESP:    if (s_axil_rready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Loaded only on the AR handshake, so the response stays stable while rvalid waits on rready.
    bsg_dff_reset_en #(
        .width_p     (axil_data_width_p + 2),
        .reset_val_p ('0)
    ) resp_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (ar_hs),
        .data_i  ({rdata_d, rresp_d}),
        .data_o  (resp_q)
    );

    assign s_axil_rdata_o = resp_q[axil_data_width_p+1:2];
    assign s_axil_rresp_o = resp_q[1:0];

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_rx_rd.sv
// Self-checking bench for bsg_manycore_link_to_axil_rx_rd with a queue-based RX stage model
// and an expected-response scoreboard. Honours BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN.
module tb_bsg_manycore_link_to_axil_rx_rd;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready_o;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          rvalid_o;
    logic          rready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_v = 1'b0;
    logic          rx_ready_o;
    logic [CW-1:0] rx_credits = '0;

    bsg_manycore_link_to_axil_rx_rd #(
        .axil_data_width_p   (DW),
        .axil_addr_width_p   (AW),
        .req_credits_width_p (CW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .s_axil_araddr_i  (araddr),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready_o),
        .s_axil_rdata_o   (rdata_o),
        .s_axil_rresp_o   (rresp_o),
        .s_axil_rvalid_o  (rvalid_o),
        .s_axil_rready_i  (rready),
        .rx_data_i        (rx_data),
        .rx_v_i           (rx_v),
        .rx_ready_o       (rx_ready_o),
        .rx_credits_i     (rx_credits)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            pops     = 0;
    int            ar_count = 0;
    int            r_count  = 0;
    bit            rx_ready_seen = 1'b0;
    logic [DW-1:0] uflow_m  = '0;
    logic [DW-1:0] fifo[$];
    rsp_t          exp_q[$];
    rsp_t          act_q[$];
    int            ar_cyc_q[$];

    task automatic drive_rx();
        rx_v       = (fifo.size() != 0);
        rx_data    = (fifo.size() != 0) ? fifo[0] : '0;
        rx_credits = CW'(fifo.size());
    endtask

    task automatic push_rx(input logic [DW-1:0] w);
        fifo.push_back(w);
        drive_rx();
    endtask

    // Expected response for a read accepted now, from the RX model state before any pop.
    task automatic model_read(input logic [AW-1:0] a, output rsp_t r);
        logic [5:0] off;
        off = a[7:2];
        r.data = '0;
        r.resp = 2'b11;
        if (off == 6'd0) begin
            if (fifo.size() != 0) begin
                r.data = fifo[0];
                r.resp = 2'b00;
            end else begin
                r.resp = 2'b10;
                uflow_m = uflow_m + 1;
            end
        end else if (off == 6'd1) begin
            r.data = DW'(fifo.size());
            r.resp = 2'b00;
        end
`ifdef BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN
        else if (off == 6'd2) begin
            r.data = uflow_m;
            r.resp = 2'b00;
        end
`endif
    endtask

    // One clock: observe handshakes mid-cycle, then apply the RX pop just after the edge.
    task automatic tick();
        rsp_t e, a;
        bit   pop_hs;
        @(negedge clk);
        if (!reset_i && arvalid && arready_o) begin
            model_read(araddr, e);
            exp_q.push_back(e);
            ar_cyc_q.push_back(cyc);
            ar_count++;
        end
        if (!reset_i && rvalid_o && rready) begin
            a.data = rdata_o;
            a.resp = rresp_o;
            act_q.push_back(a);
            r_count++;
        end
        if (rx_ready_o) rx_ready_seen = 1'b1;
        pop_hs = rx_ready_o && rx_v && !reset_i;
        @(posedge clk);
        cyc++;
        if (reset_i) uflow_m = '0;
        #1;
        if (pop_hs) begin
            void'(fifo.pop_front());
            pops++;
        end
        drive_rx();
    endtask

    task automatic read(input logic [AW-1:0] a, output bit rvalid_next);
        int a0, r0, n;
        a0 = ar_count;
        r0 = r_count;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        while (ar_count == a0 && n < 20) begin tick(); n++; end
        arvalid = 1'b0;
        rvalid_next = rvalid_o;
        n = 0;
        while (r_count == r0 && n < 20) begin tick(); n++; end
        n_checks++;
        if (r_count == r0) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: got %0d responses, required %0d", a, r_count - r0, 1);
        end
    endtask

    task automatic cmp_sb(input string name);
        rsp_t e, a;
        n_checks++;
        if (exp_q.size() == 0 || act_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty exp=%0d act=%0d", name, exp_q.size(), act_q.size());
        end else begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b",
                         name, a.data, a.resp, e.data, e.resp);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        n_checks++;
        if ({arready_o, rvalid_o, rx_ready_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got arready/rvalid/rx_ready=%b, required 000", {arready_o, rvalid_o, rx_ready_o});
        end
        n_checks++;
        if (rdata_o !== '0 || rresp_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rsp: got rdata=%h rresp=%b, required 0 00", rdata_o, rresp_o);
        end
        tick();
        reset_i = 1'b0;
        tick();
        n_checks++;
        if (arready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_arready: got %b, required 1", arready_o);
        end
    endtask

    task automatic test_rx_data();
        int p0;
        bit rv;
        push_rx(32'hDEADBEEF);
        p0 = pops;
        read(32'h0000_0000, rv);
        n_checks++;
        if (rv !== 1'b1) begin
            n_fail++;
            $display("FAIL rvalid_latency: rvalid after AR edge=%b, required 1", rv);
        end
        n_checks++;
        if (act_q.size() != 0 && act_q[0].data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL data_word: got %h, required DEADBEEF", act_q[0].data);
        end
        cmp_sb("rx_data_read");
        n_checks++;
        if (pops - p0 != 1) begin
            n_fail++;
            $display("FAIL data_pops: got %0d, required 1", pops - p0);
        end
    endtask

    task automatic test_empty();
        bit rv;
        rx_ready_seen = 1'b0;
        read(32'h0000_0000, rv);
        cmp_sb("empty_read");
        n_checks++;
        if (rx_ready_seen) begin
            n_fail++;
            $display("FAIL empty_no_pop: got rx_ready seen=1, required 0");
        end
        read(32'h0000_0008, rv);
`ifdef BSG_MANYCORE_AXIL_RX_UFLOW_CNT_EN
        n_checks++;
        if (act_q.size() != 0 && act_q[0].data !== 32'd1) begin
            n_fail++;
            $display("FAIL uflow_count: got %0d, required 1", act_q[0].data);
        end
`endif
        cmp_sb("uflow_offset_read");
    endtask

    task automatic test_occ();
        int p0;
        bit rv;
        push_rx(32'h1111_0001);
        push_rx(32'h1111_0002);
        push_rx(32'h1111_0003);
        p0 = pops;
        read(32'h0000_0004, rv);
        n_checks++;
        if (act_q.size() != 0 && act_q[0] !== {32'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL occ_value: got data=%0d resp=%b, required 3 00", act_q[0].data, act_q[0].resp);
        end
        cmp_sb("occ_read");
        read(32'hFFFF_FF05, rv);
        cmp_sb("occ_alias_read");
        n_checks++;
        if (pops != p0) begin
            n_fail++;
            $display("FAIL occ_no_pop: got %0d pops, required 0", pops - p0);
        end
    endtask

    task automatic test_decerr();
        bit rv;
        read(32'h0000_000C, rv);
        n_checks++;
        if (act_q.size() != 0 && act_q[0] !== {32'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL decerr_0c: got data=%h resp=%b, required 0 11", act_q[0].data, act_q[0].resp);
        end
        cmp_sb("decerr_0c");
        read(32'h0000_0008, rv);
        cmp_sb("offset_08");
        read(32'h0000_00FC, rv);
        cmp_sb("decerr_fc");
    endtask

    task automatic test_stall();
        int            p0, n;
        logic [DW-1:0] held;
        p0 = pops;
        araddr  = 32'h0;
        arvalid = 1'b1;
        rready  = 1'b0;
        n = 0;
        while (ar_count == 0 + ar_count && !rvalid_o && n < 20) begin tick(); n++; end
        held = rdata_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (arready_o !== 1'b0 || rvalid_o !== 1'b1 || rdata_o !== held) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got arready=%b rvalid=%b rdata=%h, required 0 1 %h",
                         i, arready_o, rvalid_o, rdata_o, held);
            end
        end
        n_checks++;
        if (pops - p0 != 1) begin
            n_fail++;
            $display("FAIL stall_pops: got %0d, required 1", pops - p0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        while (rvalid_o && n < 20) begin tick(); n++; end
        cmp_sb("stall_read");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words[$];
        int            a0, r0, n;
        while (fifo.size() < 4) push_rx($urandom());
        words = fifo;
        exp_q.delete();
        act_q.delete();
        ar_cyc_q.delete();
        a0 = ar_count;
        r0 = r_count;
        araddr  = 32'h0;
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        while (ar_count - a0 < 4 && n < 30) begin tick(); n++; end
        arvalid = 1'b0;
        n = 0;
        while (r_count - r0 < 4 && n < 30) begin tick(); n++; end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (act_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got no response, required %h", i, words[i]);
            end else if (act_q[0] !== {words[i], 2'b00}) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got %h/%b, required %h/00", i, act_q[0].data, act_q[0].resp, words[i]);
                void'(act_q.pop_front());
            end else begin
                void'(act_q.pop_front());
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (ar_cyc_q.size() < 4 || ar_cyc_q[i] - ar_cyc_q[i-1] != 2) begin
                n_fail++;
                $display("FAIL b2b_ar_spacing[%0d]: got %0d, required 2", i,
                         (ar_cyc_q.size() < 4) ? -1 : ar_cyc_q[i] - ar_cyc_q[i-1]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_in_resp();
        int p0, s0, n;
        push_rx(32'hCAFE_0001);
        araddr  = 32'h0;
        arvalid = 1'b1;
        rready  = 1'b0;
        n = 0;
        while (!rvalid_o && n < 20) begin tick(); n++; end
        arvalid = 1'b0;
        p0 = pops;
        s0 = fifo.size();
        reset_i = 1'b1;
        tick();
        n_checks++;
        if (rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_resp_rvalid: got %b, required 0", rvalid_o);
        end
        reset_i = 1'b0;
        rready  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pops != p0 || fifo.size() != s0 || rx_credits !== CW'(s0)) begin
            n_fail++;
            $display("FAIL reset_in_resp_credits: got pops+%0d credits=%0d, required pops+0 credits=%0d",
                     pops - p0, rx_credits, s0);
        end
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_rx();
        test_reset();
        test_rx_data();
        test_empty();
        test_occ();
        test_decerr();
        test_stall();
        test_back_to_back();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
